// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter among NREQ byte-stream requesters, with frame lock and watchdog.
// Latency: req_valid in IDLE -> tx_start next cycle; locked frame tx_done -> next tx_start next cycle.
// Backpressure: req_ready pulses once per accepted byte; the next start waits for tx_done or watchdog abort.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int DW          = 8,
    parameter int TIMEOUT_CYC = 60000,
    parameter int CW          = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx_start,
    output logic [DW-1:0]            tx_data,
    input  logic                     tx_done,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     grant_active,
    output logic                     timeout_err
);

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [IW-1:0] last_winner_q, last_winner_d;
    logic          grant_active_q, grant_active_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          last_q, last_d;
    logic [CW-1:0] wd_q, wd_d;

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [DW-1:0] win_data;
    logic [DW-1:0] gnt_data;
    logic          gnt_valid;
    logic          wd_expire;
    logic          abort;

    // Rotating priority: first valid index after the previous winner, wrapping modulo NREQ.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_winner_q) + k) % NREQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

    assign win_data  = req_data[int'(win_idx)*DW +: DW];
    assign gnt_data  = req_data[int'(grant_id_q)*DW +: DW];
    assign gnt_valid = req_valid[grant_id_q];
    assign wd_expire = (wd_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id_q;
        last_winner_d  = last_winner_q;
        grant_active_d = grant_active_q;
        tx_data_d      = tx_data_q;
        last_d         = last_q;
        wd_d           = wd_q;
        abort          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_id_d     = win_idx;
                    grant_active_d = 1'b1;
                    tx_data_d      = win_data;
                    last_d         = req_last[win_idx];
                    state_d        = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the expiry cycle still counts as success.
                if (tx_done) begin
                    wd_d = '0;
                    if (last_q) begin
                        last_winner_d  = grant_id_q;
                        grant_active_d = 1'b0;
                        state_d        = S_IDLE;
                    end else if (gnt_valid) begin
                        tx_data_d = gnt_data;
                        last_d    = req_last[grant_id_q];
                        state_d   = S_LAUNCH;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else if (wd_expire) begin
                    abort          = 1'b1;
                    last_winner_d  = grant_id_q;
                    grant_active_d = 1'b0;
                    state_d        = S_IDLE;
                end else begin
                    wd_d = wd_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (gnt_valid) begin
                    tx_data_d = gnt_data;
                    last_d    = req_last[grant_id_q];
                    state_d   = S_LAUNCH;
                end else if (wd_expire) begin
                    abort          = 1'b1;
                    last_winner_d  = grant_id_q;
                    grant_active_d = 1'b0;
                    state_d        = S_IDLE;
                end else begin
                    wd_d = wd_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            grant_id_q     <= '0;
            last_winner_q  <= IW'(NREQ - 1);
            grant_active_q <= 1'b0;
            tx_data_q      <= '0;
            last_q         <= 1'b0;
            wd_q           <= '0;
        end else begin
            state_q        <= state_d;
            grant_id_q     <= grant_id_d;
            last_winner_q  <= last_winner_d;
            grant_active_q <= grant_active_d;
            tx_data_q      <= tx_data_d;
            last_q         <= last_d;
            wd_q           <= wd_d;
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_LAUNCH) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    assign tx_start     = (state_q == S_LAUNCH);
    assign tx_data      = tx_data_q;
    assign grant_id     = grant_id_q;
    assign grant_active = grant_active_q;
    assign timeout_err  = abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: NREQ=4, DW=8, watchdog shortened to 50 cycles.
// Inputs change and outputs are sampled 1 ns after the rising edge.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic [1:0]  grant_id;
    logic        grant_active;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.NREQ(4), .DW(8), .TIMEOUT_CYC(50), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .grant_id(grant_id), .grant_active(grant_active),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req_valid = '0; req_last = '0; req_data = '0; tx_done = 1'b0;
        rst_n = 1'b0;
        tick; tick;
        rst_n = 1'b1;
    endtask

    task automatic pulse_done;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick;
            if (tx_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [16:0] outs;
        rst_n = 1'b0; req_valid = 4'hF; req_last = 4'hF; req_data = 32'hDEADBEEF;
        #3;
        outs = {tx_start, req_ready, tx_data, grant_id, grant_active, timeout_err};
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        tick; tick;
        outs = {tx_start, req_ready, tx_data, grant_id, grant_active, timeout_err};
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_held: got %h expected 0", outs); end
        do_reset;
    endtask

    task automatic test_single;
        do_reset;
        req_data[15:8] = 8'hA5; req_last = 4'b0010; req_valid = 4'b0010;
        tick;
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", tx_start); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b expected 0010", req_ready); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", tx_data); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_gid: got %0d expected 1", grant_id); end
        req_valid = '0;
        tick;
        checks++; if ({tx_start, req_ready} !== 5'b0) begin errors++; $display("FAIL single_start_once: got %b expected 00000", {tx_start, req_ready}); end
        repeat (5) tick;
        checks++; if ({grant_active, tx_data} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL single_hold: got %h expected 1a5", {grant_active, tx_data}); end
        pulse_done;
        checks++; if (grant_active !== 1'b0) begin errors++; $display("FAIL single_release: got %b expected 0", grant_active); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_gid_kept: got %0d expected 1", grant_id); end
    endtask

    task automatic test_fairness;
        bit ok;
        logic [1:0] e;
        logic [7:0] ed;
        logic [3:0] er;
        do_reset;
        req_data = 32'h13121110; req_last = 4'hF; req_valid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            e = 2'(n % 4);
            ed = 8'h10 + 8'(e);
            er = 4'b0001 << e;
            wait_start(ok);
            checks++; if (!ok) begin errors++; $display("FAIL fair_start_%0d: got no tx_start expected tx_start", n); end
            checks++; if (grant_id !== e) begin errors++; $display("FAIL fair_gid_%0d: got %0d expected %0d", n, grant_id, e); end
            checks++; if (req_ready !== er) begin errors++; $display("FAIL fair_ready_%0d: got %b expected %b", n, req_ready, er); end
            checks++; if (tx_data !== ed) begin errors++; $display("FAIL fair_data_%0d: got %h expected %h", n, tx_data, ed); end
            repeat (20) tick;
            pulse_done;
        end
        req_valid = '0;
    endtask

    task automatic test_frame_lock;
        do_reset;
        req_data[23:16] = 8'h31; req_last = 4'b0000; req_valid = 4'b0100;
        tick;
        checks++; if ({tx_start, grant_id, tx_data} !== {1'b1, 2'd2, 8'h31}) begin errors++; $display("FAIL lock_b1: got %h expected 231", {tx_start, grant_id, tx_data}); end
        req_data[7:0] = 8'h77; req_last[0] = 1'b1; req_valid = 4'b0101; req_data[23:16] = 8'h32;
        tick; repeat (4) tick;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL lock_wait_ready: got %b expected 0000", req_ready); end
        pulse_done;
        checks++; if ({tx_start, grant_id, tx_data} !== {1'b1, 2'd2, 8'h32}) begin errors++; $display("FAIL lock_b2: got %h expected 232", {tx_start, grant_id, tx_data}); end
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lock_b2_ready: got %b expected 0100", req_ready); end
        req_data[23:16] = 8'h33; req_last[2] = 1'b1;
        tick; repeat (4) tick;
        pulse_done;
        checks++; if ({tx_start, grant_id, tx_data} !== {1'b1, 2'd2, 8'h33}) begin errors++; $display("FAIL lock_b3: got %h expected 233", {tx_start, grant_id, tx_data}); end
        req_valid = 4'b0001;
        tick; repeat (4) tick;
        pulse_done;
        checks++; if ({grant_active, tx_start} !== 2'b00) begin errors++; $display("FAIL lock_release: got %b expected 00", {grant_active, tx_start}); end
        tick;
        checks++; if ({tx_start, grant_id, tx_data} !== {1'b1, 2'd0, 8'h77}) begin errors++; $display("FAIL lock_next: got %h expected 077", {tx_start, grant_id, tx_data}); end
    endtask

    task automatic test_hold;
        int bad;
        do_reset;
        req_data[31:24] = 8'h41; req_last = 4'b0000; req_valid = 4'b1000;
        tick;
        checks++; if ({tx_start, grant_id, tx_data} !== {1'b1, 2'd3, 8'h41}) begin errors++; $display("FAIL hold_b1: got %h expected 341", {tx_start, grant_id, tx_data}); end
        req_valid = 4'b0010; req_data[15:8] = 8'h55; req_last[1] = 1'b1;
        tick; repeat (3) tick;
        pulse_done;
        // Gap kept below the 50-cycle watchdog window.
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx_start !== 1'b0 || grant_id !== 2'd3 || grant_active !== 1'b1 || timeout_err !== 1'b0) bad++;
            tick;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_idle: got %0d bad cycles expected 0", bad); end
        req_data[31:24] = 8'h42; req_last[3] = 1'b1; req_valid = 4'b1010;
        tick;
        checks++; if ({tx_start, grant_id, tx_data} !== {1'b1, 2'd3, 8'h42}) begin errors++; $display("FAIL hold_b2: got %h expected 342", {tx_start, grant_id, tx_data}); end
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL hold_b2_ready: got %b expected 1000", req_ready); end
    endtask

    task automatic test_timeout;
        int early;
        do_reset;
        req_data[7:0] = 8'h60; req_data[15:8] = 8'h61; req_last = 4'b0011; req_valid = 4'b0011;
        tick;
        checks++; if ({tx_start, grant_id} !== {1'b1, 2'd0}) begin errors++; $display("FAIL to_grant0: got %b expected 100", {tx_start, grant_id}); end
        req_valid = 4'b0010;
        tick;
        early = 0;
        for (int k = 1; k < 50; k++) begin
            if (timeout_err !== 1'b0) early++;
            tick;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL to_early: got %0d pulses expected 0", early); end
        checks++; if ({timeout_err, grant_active} !== 2'b11) begin errors++; $display("FAIL to_pulse: got %b expected 11", {timeout_err, grant_active}); end
        tick;
        checks++; if ({timeout_err, grant_active} !== 2'b00) begin errors++; $display("FAIL to_after: got %b expected 00", {timeout_err, grant_active}); end
        tick;
        checks++; if ({tx_start, grant_id, tx_data} !== {1'b1, 2'd1, 8'h61}) begin errors++; $display("FAIL to_next: got %h expected 161", {tx_start, grant_id, tx_data}); end
        req_valid = '0;
        tick;
        repeat (49) tick;
        tx_done = 1'b1;
        #1;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_suppress: got %b expected 0", timeout_err); end
        tick;
        tx_done = 1'b0;
        checks++; if ({timeout_err, grant_active, tx_start} !== 3'b000) begin errors++; $display("FAIL to_done_wins: got %b expected 000", {timeout_err, grant_active, tx_start}); end
    endtask

    task automatic test_reset_mid;
        logic [16:0] outs;
        do_reset;
        req_data[23:16] = 8'h99; req_last = 4'hF; req_valid = 4'b0100;
        tick;
        req_valid = '0;
        tick; tick;
        #2 rst_n = 1'b0;
        #1;
        outs = {tx_start, req_ready, tx_data, grant_id, grant_active, timeout_err};
        checks++; if (outs !== '0) begin errors++; $display("FAIL mid_reset: got %h expected 0", outs); end
        tick;
        rst_n = 1'b1;
        pulse_done;
        checks++; if ({grant_active, tx_start, timeout_err} !== 3'b000) begin errors++; $display("FAIL spurious_done: got %b expected 000", {grant_active, tx_start, timeout_err}); end
        req_data = 32'h88776655; req_valid = 4'hF;
        tick;
        checks++; if ({tx_start, grant_id, tx_data} !== {1'b1, 2'd0, 8'h55}) begin errors++; $display("FAIL mid_first: got %h expected 055", {tx_start, grant_id, tx_data}); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ready: got %b expected 0001", req_ready); end
        req_valid = '0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_fairness;
        test_frame_lock;
        test_hold;
        test_timeout;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got no finish expected finish before 200000ns");
        $fatal(1);
    end

endmodule
